// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity type codes and line idle level.
// Used by both the transmit and receive paths.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/parity_calc.sv
// Combinational parity generator: XOR reduction of the payload, inverted for odd parity.
// Zero latency, no flow control; shared with the RX parity checker.
module parity_calc
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx.sv
// UART serializer: start, LSB-first data, optional parity, stop at one bit per CLK; line starts one cycle after acceptance.
// No queueing: requests are taken only while idle with Busy low, anything else is dropped.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int                CNT_W    = $clog2(DATA_WIDTH) + 1;
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  uart_state_t           state;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  par_bit_new;

  // Parity is taken from the unshifted payload at acceptance, before serialization destroys it.
  parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity_calc (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_bit_new)
  );

  // Outputs are registered from the current state, so the line lags the state by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      TX_OUT    <= LINE_IDLE;
      Busy      <= 1'b0;
      bit_cnt   <= '0;
      shift_reg <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          TX_OUT <= LINE_IDLE;
          Busy   <= 1'b0;
          // Busy is still high for the one idle cycle following the stop bit; hold off until it drops.
          if (Data_Valid && !Busy) begin
            shift_reg <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= par_bit_new;
            state     <= ST_START;
          end
        end
        ST_START: begin
          TX_OUT  <= 1'b0;
          Busy    <= 1'b1;
          bit_cnt <= '0;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          TX_OUT    <= shift_reg[0];
          Busy      <= 1'b1;
          shift_reg <= shift_reg >> 1;
          bit_cnt   <= bit_cnt + 1'b1;
          if (bit_cnt == LAST_BIT) begin
            state <= par_en_q ? ST_PARITY : ST_STOP;
          end
        end
        ST_PARITY: begin
          TX_OUT <= par_bit_q;
          Busy   <= 1'b1;
          state  <= ST_STOP;
        end
        ST_STOP: begin
          TX_OUT <= LINE_IDLE;
          Busy   <= 1'b1;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: directed frames plus randomized frames checked cycle by cycle against a frame-level line model.
module tb_uart_tx;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] P_DATA = 8'h00;
  logic       Data_Valid = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic       TX_OUT;
  logic       Busy;

  int tests_run = 0;
  int tests_failed = 0;

  uart_tx #(.DATA_WIDTH(8)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .Data_Valid (Data_Valid),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .Busy       (Busy)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      check("idle_tx", TX_OUT, 1);
      check("idle_busy", Busy, 0);
    end
  endtask

  // Strobe one frame at a negedge and follow the line through the whole frame.
  // junk_at: frame cycle where a dropped request with altered inputs is injected (-1 = none).
  // rst_at:  frame cycle after which reset is asserted to abort the frame (-1 = none).
  task automatic send_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                            input int junk_at, input int rst_at);
    logic exp_q[$];
    logic par;
    par = logic'($countones(d) % 2) ^ ptyp;
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(par);
    exp_q.push_back(1'b1);

    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; Data_Valid = 1'b1;
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("accept_tx", TX_OUT, 1);
    check("accept_busy", Busy, 0);
    for (int k = 0; k < exp_q.size(); k++) begin
      @(negedge CLK);
      Data_Valid = 1'b0;
      check($sformatf("bit%0d_tx d=%02h p=%0d%0d", k, d, pen, ptyp), TX_OUT, exp_q[k]);
      check($sformatf("bit%0d_busy", k), Busy, 1);
      if (k == junk_at) begin
        P_DATA = 8'h55; PAR_TYP = ~ptyp; PAR_EN = ~pen; Data_Valid = 1'b1;
      end
      if (k == rst_at) begin
        RST = 1'b1;
        @(negedge CLK);
        check("abort_tx", TX_OUT, 1);
        check("abort_busy", Busy, 0);
        RST = 1'b0;
        return;
      end
    end
    @(negedge CLK);
    Data_Valid = 1'b0;
    check("end_tx", TX_OUT, 1);
    check("end_busy", Busy, 0);
  endtask

  initial begin
    // Reset held for three cycles, then quiet line without requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_tx", TX_OUT, 1);
      check("rst_busy", Busy, 0);
    end
    RST = 1'b0;
    idle_cycles(3);

    send_frame(8'hA5, 1'b1, 1'b0, -1, -1);
    send_frame(8'hA5, 1'b1, 1'b1, -1, -1);
    send_frame(8'h00, 1'b1, 1'b1, -1, -1);
    send_frame(8'hFF, 1'b1, 1'b0, -1, -1);
    send_frame(8'h3C, 1'b0, 1'b0, -1, -1);
    idle_cycles(2);

    // Mid-frame request with changed inputs must be dropped, as must one during the stop bit.
    send_frame(8'h96, 1'b1, 1'b0, 5, -1);
    idle_cycles(3);
    send_frame(8'h69, 1'b0, 1'b1, 9, -1);
    idle_cycles(3);
    send_frame(8'h55, 1'b1, 1'b1, -1, -1);

    // Abort while data bit 3 is on the line, then a clean frame.
    send_frame(8'hC3, 1'b1, 1'b0, -1, 4);
    idle_cycles(2);
    send_frame(8'h81, 1'b1, 1'b0, -1, -1);

    for (int n = 0; n < 40; n++) begin
      logic [7:0] d;
      logic       pen;
      logic       ptyp;
      int         junk;
      d    = 8'($urandom);
      pen  = 1'($urandom_range(0, 1));
      ptyp = 1'($urandom_range(0, 1));
      junk = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 10)) : -1;
      send_frame(d, pen, ptyp, junk, -1);
      if (junk >= 0) idle_cycles(2);
      else           idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial transmitter of the UART block, the transmit-side counterpart of the RX oversampling/sampling path. Accepts a parallel byte with a one-cycle valid strobe, frames it (start, LSB-first data, optional parity, stop), and drives it onto the serial line at one bit per clock cycle. The clock is the TX baud clock produced by the system clock divider, so one `CLK` cycle equals one bit period. `Busy` is exported to the system controller and the FIFO read side to throttle the next word.

## Interface
Parameters:
- `DATA_WIDTH`, 8: payload bits per frame.

Ports:
- `CLK`, in, 1: TX baud clock. Single clock domain; all logic updates on the rising edge.
- `RST`, in, 1: synchronous, active-high reset.
- `P_DATA`, in, `DATA_WIDTH`: parallel payload. Sampled only at acceptance.
- `Data_Valid`, in, 1: one-cycle request strobe.
- `PAR_EN`, in, 1: parity-enable bit from the configuration register. Sampled at acceptance.
- `PAR_TYP`, in, 1: parity type. 0 selects even parity, 1 selects odd. Sampled at acceptance.
- `TX_OUT`, out, 1: serial line, registered. Idles high.
- `Busy`, out, 1: registered. High while a frame is on the line.

## Operation
- **Reset.** `RST` is sampled at the clock edge. It forces state IDLE, `TX_OUT=1`, `Busy=0`, bit counter 0, and clears the shift and parity registers. A reset in mid-frame aborts the frame. The line returns high on the edge where reset is sampled, and no partial stop bit is emitted.
- **FSM states.** IDLE, START, DATA, PARITY, STOP.
  - **IDLE:** `TX_OUT=1`, `Busy=0`. If `Data_Valid=1`, latch `P_DATA`, `PAR_EN` and `PAR_TYP`, compute the parity bit (XOR of all data bits, inverted when `PAR_TYP=1`), then go to START.
  - **START:** `TX_OUT=0`, `Busy=1`. Go to DATA.
  - **DATA:** `TX_OUT` is the shift-register LSB, so data goes out LSB first. The register shifts right and the counter increments every cycle. After `DATA_WIDTH` cycles, go to PARITY if the latched `PAR_EN=1`, otherwise go to STOP.
  - **PARITY:** `TX_OUT` is the latched parity bit. Go to STOP.
  - **STOP:** `TX_OUT=1`, `Busy=1`. Go to IDLE.
- **Ignored requests.** `Data_Valid` is ignored in every state except IDLE. A request arriving while busy is dropped, and the upstream side must wait for `Busy=0`.
- **Minimum gap.** At least one IDLE cycle always separates consecutive frames, so there are no back-to-back stop/start pairs.
- **Stable frame contents.** Changes on `P_DATA`, `PAR_EN` or `PAR_TYP` after acceptance do not affect the frame in flight.
- **Counter width.** The bit counter is `$clog2(DATA_WIDTH)+1` bits wide and is cleared on entry to DATA. There is no wrap-around within a frame.

## Timing
- **Latency.** `Data_Valid` is sampled high in IDLE at edge N. `TX_OUT=0` and `Busy=1` appear after edge N+1.
- **Bit schedule.** Data bit i is driven in cycle N+2+i. Parity (if enabled) is driven in cycle N+2+`DATA_WIDTH`. Stop is driven in the following cycle.
- **Frame length.** 1+`DATA_WIDTH`+1 cycles, or 1+`DATA_WIDTH`+2 with parity (10 or 11 for 8 bits).
- **Busy.** `Busy` falls with the transition back to IDLE. The earliest next acceptance is the cycle in which `Busy` is first seen low.
- **Glitch-free output.** `TX_OUT` and `Busy` come directly from flops and are never combinational from inputs.

## Structure
- **Shared package `uart_pkg`:** FSM state encoding, parity type constants `PAR_EVEN=0` and `PAR_ODD=1`, and the line idle level. The RX side uses the same package.
- **Sub-module `parity_calc`:** combinational XOR reduction of the latched data plus type select. It is instantiated once and reused by the RX parity checker.
- **Top level:** the FSM, serializer shift register, bit counter and output mux stay in `uart_tx`.

## Test plan
- **Reset state:** hold `RST` for 3 cycles → `TX_OUT=1` and `Busy=0` throughout and after release, with no activity without `Data_Valid`.
- **Even parity:** `P_DATA=0xA5`, `PAR_EN=1`, `PAR_TYP=0` → `TX_OUT` sequence 0,1,0,1,0,0,1,0,1,0,1 over 11 cycles starting one cycle after the strobe. `Busy` is high for exactly 11 cycles.
- **Odd parity:** `0xA5` with `PAR_TYP=1` → parity bit 1. `0x00` with `PAR_TYP=1` → parity 1. `0xFF` with `PAR_TYP=0` → parity 0.
- **Parity disabled:** `P_DATA=0x3C`, `PAR_EN=0` → 0,0,0,1,1,1,1,0,0,1 over 10 cycles, then idle high.
- **Busy protection:** pulse `Data_Valid` with `0x55` mid-frame and change `P_DATA`/`PAR_TYP` after acceptance → the in-flight frame is unchanged and the second request is dropped. A new strobe after `Busy=0` sends a correct frame.
- **Reset mid-frame:** assert `RST` during DATA bit 3 → `TX_OUT=1` and `Busy=0` on the next edge. After reset releases, a fresh frame of `0x81` with parity enabled transmits correctly.
